mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
- Main control unit for the multi-cycle MIPS core; sits directly upstream of the datapath and drives every one of its select and enable inputs.
- Consumes opcode/funct from the instruction register and the ALU zero flag.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Holds memory-access states with a mem_req/mem_ready handshake.
- Counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset; asynchronous, active-low.
- opcode  in  6  instr[31:26].
- funct  in  6  instr[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access requested.
- memwrite  out  1  write strobe, valid with mem_req.
- iord  out  1  address select, 0=pc, 1=aluout.
- irwrite  out  1  instruction register load.
- pcen  out  1  pc register load.
- pcsrc  out  1  pc next select, 0=aluresult, 1=aluout.
- alusrca  out  1  0=pc, 1=A.
- alusrcb  out  2  00=B, 01=4, 10=signimm, 11=signimm<<2.
- regdst  out  1  0=rt, 1=rd.
- memtoreg  out  1  0=aluout, 1=data.
- regwrite  out  1  register file write.
- aluop  out  2  00 add, 01 sub, 10 funct.
- alucontrol  out  3  ALU operation.
- state  out  4  current state, for debug.
- illegal_op  out  1  one-cycle pulse on an unsupported instruction.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- While reset is low:
  - state=FETCH (0), retired=0, illegal_op=0.
  - mem_req, irwrite, pcen, regwrite and memwrite are forced to 0.
  - Other outputs take their FETCH values.
- Outputs are Moore functions of state, except pcen in FETCH/BRANCH and irwrite. Any signal not listed for a state is 0.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10.
- Codes 11-15 are unreachable; if entered, go to FETCH.
- FETCH:
  - Outputs: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=00.
  - irwrite=pcen=mem_ready.
  - Next state: DECODE if mem_ready, otherwise stay in FETCH.
- DECODE:
  - Outputs: alusrca=0, alusrcb=11, aluop=00 (branch target into aluout).
  - Next state by opcode:
    - 100011 or 101011 -> MEMADR.
    - 000000 -> EXECUTE.
    - 000100 -> BRANCH.
    - 001000 -> ADDIEXEC.
    - Anything else -> FETCH with illegal_op=1.
  - R-type with funct outside {100000, 100010, 100100, 100101, 101010} is also illegal -> FETCH with illegal_op=1.
  - An illegal instruction writes no state and is not counted.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Next: MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, iord=1. Stay until mem_ready, then MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Next: FETCH.
- MEMWR:
  - Outputs: mem_req=1, memwrite=1, iord=1.
  - Memory commits on the mem_ready cycle.
  - On mem_ready -> FETCH; otherwise hold with all outputs stable.
- EXECUTE: alusrca=1, alusrcb=00, aluop=10. Next: ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1. Next: FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=1, pcen=zero. Next: FETCH.
- ADDIEXEC: alusrca=1, alusrcb=10, aluop=00. Next: ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. Next: FETCH.
- alucontrol, combinational from aluop and funct:
  - aluop=00 -> 010; aluop=01 -> 110.
  - aluop=10: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, other -> 010.
- retired:
  - +1 on the clock edge leaving MEMWB, ALUWB, ADDIWB or BRANCH (taken or not), and leaving MEMWR with mem_ready=1.
  - Wraps modulo 2^CNT_W.
- Latencies with zero-wait memory:
  - lw 5 cycles, sw 4, R-type 4, addi 4, beq 3.
  - Each wait cycle on mem_ready adds 1.
- Reset asserted mid-instruction aborts it immediately with no further writes. After release, execution starts in FETCH.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.

Optional Feature:
- Macro: MC_CTRL_BNE_EN.
- Defined:
  - Opcode 000101 (bne) is decoded in DECODE -> BRANCH.
  - An internal registered flag records bne vs beq.
  - In BRANCH, pcen = ~zero for bne and zero for beq.
  - bne retires like beq.
- Undefined: 000101 is illegal (illegal_op pulse, return to FETCH).

Test Plan:
- Reset low for 3 cycles then release, mem_ready=1 -> state=0, mem_req=1, irwrite=pcen=1 on the first post-reset cycle, DECODE next; retired=0.
- lw (opcode 100011), mem_ready low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; regwrite=1 and memtoreg=1 only in MEMWB; retired +1.
- R-type funct 101010 -> in EXECUTE aluop=10, alucontrol=111; ALUWB regdst=1, regwrite=1; 4 cycles total.
- beq with zero=1 then zero=0 -> BRANCH pcsrc=1, alucontrol=110, pcen=1 then 0; retired +1 both times.
- Opcode 111111 -> DECODE pulses illegal_op=1 for 1 cycle, returns to FETCH, no regwrite/memwrite, retired unchanged; with MC_CTRL_BNE_EN, 000101 with zero=0 gives pcen=1.
- sw with reset dropped during MEMWR (mem_ready=0) -> memwrite/mem_req fall to 0 asynchronously, state=0, retired=0.

Source files
------------

// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mc_control_fsm
// Description : Multi-cycle MIPS main control FSM with memory handshake and
//               retired-instruction counter. MC_CTRL_BNE_EN adds bne decode.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             memwrite,
    output logic             iord,
    output logic             irwrite,
    output logic             pcen,
    output logic             pcsrc,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic             regdst,
    output logic             memtoreg,
    output logic             regwrite,
    output logic [1:0]       aluop,
    output logic [2:0]       alucontrol,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_retired;
    logic               w_is_bne;
    logic               w_funct_ok;
    logic               w_mem_req;
    logic               w_memwrite;
    logic               w_irwrite;
    logic               w_pcen;
    logic               w_regwrite;
    logic               w_illegal;
    logic               w_retire;

    assign w_funct_ok = funct inside {6'b100000, 6'b100010, 6'b100100,
                                      6'b100101, 6'b101010};

`ifdef MC_CTRL_BNE_EN
    localparam logic [5:0] c_OP_BNE = 6'b000101;
    logic r_is_bne;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_is_bne <= 1'b0;
        else if (r_state == DECODE)
            r_is_bne <= (opcode == c_OP_BNE);
    end
    assign w_is_bne = r_is_bne;
`else
    assign w_is_bne = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= FETCH;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next     = FETCH;
        w_mem_req  = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_pcen     = 1'b0;
        w_regwrite = 1'b0;
        w_illegal  = 1'b0;
        w_retire   = 1'b0;
        iord       = 1'b0;
        pcsrc      = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        aluop      = 2'b00;
        case (r_state)
            FETCH: begin
                w_mem_req = 1'b1;
                alusrcb   = 2'b01;
                w_irwrite = mem_ready;
                w_pcen    = mem_ready;
                w_next    = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (opcode)
                    c_OP_LW, c_OP_SW: w_next = MEMADR;
                    c_OP_RTYPE: begin
                        w_next    = w_funct_ok ? EXECUTE : FETCH;
                        w_illegal = ~w_funct_ok;
                    end
                    c_OP_BEQ:  w_next = BRANCH;
`ifdef MC_CTRL_BNE_EN
                    c_OP_BNE:  w_next = BRANCH;
`endif
                    c_OP_ADDI: w_next = ADDIEXEC;
                    default:   w_illegal = 1'b1;
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_next  = (opcode == c_OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                w_mem_req = 1'b1;
                iord      = 1'b1;
                w_next    = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                memtoreg   = 1'b1;
                w_regwrite = 1'b1;
                w_retire   = 1'b1;
            end
            MEMWR: begin
                w_mem_req  = 1'b1;
                w_memwrite = 1'b1;
                iord       = 1'b1;
                w_retire   = mem_ready;
                w_next     = mem_ready ? FETCH : MEMWR;
            end
            EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                w_next  = ALUWB;
            end
            ALUWB: begin
                regdst     = 1'b1;
                w_regwrite = 1'b1;
                w_retire   = 1'b1;
            end
            BRANCH: begin
                alusrca  = 1'b1;
                aluop    = 2'b01;
                pcsrc    = 1'b1;
                w_pcen   = w_is_bne ? ~zero : zero;
                w_retire = 1'b1;
            end
            ADDIEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_next  = ADDIWB;
            end
            ADDIWB: begin
                w_regwrite = 1'b1;
                w_retire   = 1'b1;
            end
            default: w_next = FETCH;
        endcase
    end

    // Side-effecting strobes are gated by reset so an abort lands instantly.
    assign mem_req    = w_mem_req  & reset;
    assign memwrite   = w_memwrite & reset;
    assign irwrite    = w_irwrite  & reset;
    assign pcen       = w_pcen     & reset;
    assign regwrite   = w_regwrite & reset;
    assign illegal_op = w_illegal  & reset;
    assign state      = r_state;

    always_comb begin
        alucontrol = 3'b010;
        case (aluop)
            2'b01: alucontrol = 3'b110;
            2'b10: begin
                case (funct)
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
            default: alucontrol = 3'b010;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_retired <= '0;
        else if (w_retire)
            r_retired <= r_retired + CNT_W'(1);
    end
    assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_control_fsm
// Description : Scoreboard bench for mc_control_fsm; per-cycle expectations
//               come from an instruction-level model of the control rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_control_fsm;

    localparam int CNT_W = 4;
`ifdef MC_CTRL_BNE_EN
    localparam bit c_BNE_EN = 1'b1;
`else
    localparam bit c_BNE_EN = 1'b0;
`endif

    typedef logic [25:0] vec_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [5:0]       opcode = 6'd0;
    logic [5:0]       funct = 6'd0;
    logic             zero = 1'b0;
    logic             mem_ready = 1'b0;
    logic             mem_req, memwrite, iord, irwrite, pcen, pcsrc, alusrca;
    logic [1:0]       alusrcb, aluop;
    logic             regdst, memtoreg, regwrite, illegal_op;
    logic [2:0]       alucontrol;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;

    vec_t             exp_q[$];
    vec_t             act;
    logic [CNT_W-1:0] exp_ret = '0;
    int               n_checks = 0;
    int               n_pass = 0;

    always #5 clk = ~clk;

    mc_control_fsm #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req),
        .memwrite(memwrite), .iord(iord), .irwrite(irwrite), .pcen(pcen),
        .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .aluop(aluop), .alucontrol(alucontrol), .state(state),
        .illegal_op(illegal_op), .retired(retired)
    );

    assign act = {state, mem_req, memwrite, iord, irwrite, pcen, pcsrc,
                  alusrca, alusrcb, regdst, memtoreg, regwrite, aluop,
                  alucontrol, illegal_op, retired};

    // Expected outputs for one cycle spent in state st.
    function automatic vec_t model(int st, bit rst_low, bit mr, bit z,
                                   bit bne, bit ill, logic [5:0] fn,
                                   logic [CNT_W-1:0] ret);
        logic mreq, mw, io, irw, pce, pcs, asa, rd, m2r, rw, il;
        logic [1:0] asb, aop;
        logic [2:0] ac;
        {mreq, mw, io, irw, pce, pcs, asa, rd, m2r, rw, il} = '0;
        asb = 2'b00;
        aop = 2'b00;
        if (rst_low) st = 0;
        case (st)
            0:  begin mreq = 1; asb = 2'b01; irw = mr; pce = mr; end
            1:  begin asb = 2'b11; il = ill; end
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mreq = 1; io = 1; end
            4:  begin m2r = 1; rw = 1; end
            5:  begin mreq = 1; mw = 1; io = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rd = 1; rw = 1; end
            8:  begin asa = 1; aop = 2'b01; pcs = 1; pce = bne ? !z : z; end
            9:  begin asa = 1; asb = 2'b10; end
            10: rw = 1;
            default: ;
        endcase
        if (rst_low) begin
            {mreq, irw, pce, rw, mw, il} = '0;
            ret = '0;
        end
        if (aop == 2'b00)      ac = 3'b010;
        else if (aop == 2'b01) ac = 3'b110;
        else begin
            case (fn)
                6'b100010: ac = 3'b110;
                6'b100100: ac = 3'b000;
                6'b100101: ac = 3'b001;
                6'b101010: ac = 3'b111;
                default:   ac = 3'b010;
            endcase
        end
        return {4'(st), mreq, mw, io, irw, pce, pcs, asa, asb, rd, m2r, rw,
                aop, ac, il, ret};
    endfunction

    task automatic cycle(int st, bit mr, bit z, bit bne, bit ill, bit retire);
        reset     = 1'b1;
        mem_ready = mr;
        zero      = z;
        exp_q.push_back(model(st, 1'b0, mr, z, bne, ill, funct, exp_ret));
        if (retire) exp_ret = exp_ret + 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_cycle();
        reset     = 1'b0;
        mem_ready = 1'($urandom);
        zero      = 1'($urandom);
        exp_ret   = '0;
        exp_q.push_back(model(0, 1'b1, mem_ready, zero, 1'b0, 1'b0, funct, exp_ret));
        @(posedge clk);
        #1;
    endtask

    // Walks one instruction through its architectural cycle sequence.
    task automatic run_instr(logic [5:0] op, logic [5:0] fn, bit zv, int wf,
                             int wm, bit abort_sw);
        bit is_lw, is_sw, is_r, is_beq, is_bne, is_addi, ill;
        opcode  = op;
        funct   = fn;
        is_lw   = (op == 6'b100011);
        is_sw   = (op == 6'b101011);
        is_r    = (op == 6'b000000) && (fn inside {6'b100000, 6'b100010,
                   6'b100100, 6'b100101, 6'b101010});
        is_beq  = (op == 6'b000100);
        is_bne  = (op == 6'b000101) && c_BNE_EN;
        is_addi = (op == 6'b001000);
        ill     = !(is_lw || is_sw || is_r || is_beq || is_bne || is_addi);
        for (int i = 0; i < wf; i++) cycle(0, 1'b0, 1'($urandom), 0, 0, 0);
        cycle(0, 1'b1, 1'($urandom), 0, 0, 0);
        cycle(1, 1'($urandom), 1'($urandom), 0, ill, 0);
        if (is_lw) begin
            cycle(2, 1'($urandom), 1'($urandom), 0, 0, 0);
            for (int i = 0; i < wm; i++) cycle(3, 1'b0, 1'($urandom), 0, 0, 0);
            cycle(3, 1'b1, 1'($urandom), 0, 0, 0);
            cycle(4, 1'($urandom), 1'($urandom), 0, 0, 1);
        end else if (is_sw) begin
            cycle(2, 1'($urandom), 1'($urandom), 0, 0, 0);
            if (abort_sw) begin
                cycle(5, 1'b0, 1'($urandom), 0, 0, 0);
                repeat (2) reset_cycle();
            end else begin
                for (int i = 0; i < wm; i++) cycle(5, 1'b0, 1'($urandom), 0, 0, 0);
                cycle(5, 1'b1, 1'($urandom), 0, 0, 1);
            end
        end else if (is_r) begin
            cycle(6, 1'($urandom), 1'($urandom), 0, 0, 0);
            cycle(7, 1'($urandom), 1'($urandom), 0, 0, 1);
        end else if (is_beq || is_bne) begin
            cycle(8, 1'($urandom), zv, is_bne, 0, 1);
        end else if (is_addi) begin
            cycle(9, 1'($urandom), 1'($urandom), 0, 0, 0);
            cycle(10, 1'($urandom), 1'($urandom), 0, 0, 1);
        end
    endtask

    initial begin : monitor
        vec_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (act === e) n_pass++;
                else $display("FAIL cycle_outputs t=%0t state=%0d act=%h exp=%h",
                              $time, state, act, e);
            end
        end
    end

    initial begin : stimulus
        logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [5:0] op, fn;
        int sel;
        @(posedge clk);
        #1;
        repeat (3) reset_cycle();
        run_instr(6'b100011, 6'd0, 1'b0, 0, 2, 1'b0);       // lw, 2 waits
        run_instr(6'b000000, 6'b101010, 1'b0, 0, 0, 1'b0);  // slt
        run_instr(6'b000100, 6'd0, 1'b1, 0, 0, 1'b0);       // beq taken
        run_instr(6'b000100, 6'd0, 1'b0, 1, 0, 1'b0);       // beq not taken
        run_instr(6'b111111, 6'd0, 1'b0, 0, 0, 1'b0);       // illegal opcode
        run_instr(6'b000101, 6'd0, 1'b0, 0, 0, 1'b0);       // bne, zero=0
        run_instr(6'b000000, 6'b000111, 1'b0, 0, 0, 1'b0);  // illegal funct
        run_instr(6'b001000, 6'd0, 1'b0, 0, 0, 1'b0);       // addi
        run_instr(6'b101011, 6'd0, 1'b0, 1, 1, 1'b0);       // sw
        run_instr(6'b101011, 6'd0, 1'b0, 0, 0, 1'b1);       // sw aborted by reset
        for (int n = 0; n < 250; n++) begin
            sel = int'($urandom_range(0, 7));
            fn  = 6'($urandom);
            case (sel)
                0: op = 6'b100011;
                1: op = 6'b101011;
                2: begin op = 6'b000000; fn = fns[$urandom_range(0, 4)]; end
                3: op = 6'b000000;
                4: op = 6'b000100;
                5: op = 6'b000101;
                6: op = 6'b001000;
                default: op = 6'($urandom);
            endcase
            run_instr(op, fn, 1'($urandom), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 2)), ($urandom_range(0, 19) == 0));
        end
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
